// File: rtl/sim_pingpong_bram.sv
// Multi-bank ping-pong buffer RAM. The producer fills the bank at wr_ptr and
// the consumer drains the bank at rd_ptr. Per-bank full flags pass ownership
// between the two sides, strictly in ring order.
module sim_pingpong_bram #(
  parameter int RAM_WIDTH  = 64,
  parameter int RAM_DEPTH  = 1024,
  parameter int NUM_BUFS   = 2,
  parameter int RD_LATENCY = 1,
  localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int BE_W   = RAM_WIDTH / 8,
  localparam int BID_W  = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic                 wea,
  input  logic [BE_W-1:0]      bea,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 wr_commit,
  output logic                 wr_buf_ready,
  output logic [BID_W-1:0]     wr_buf_id,
  input  logic                 enb,
  input  logic [ADDR_W-1:0]    addrb,
  input  logic                 regceb,
  input  logic                 rd_release,
  output logic                 rd_buf_valid,
  output logic [BID_W-1:0]     rd_buf_id,
  output logic [RAM_WIDTH-1:0] doutb,
  output logic                 doutb_valid,
  output logic                 cmd_err
);

  // With an output register, a stage-1 result waits there until regceb takes it.
  localparam bit HOLD1 = (RD_LATENCY == 2);

  logic [NUM_BUFS-1:0]  full;
  logic [BID_W-1:0]     wr_ptr, rd_ptr;
  logic [RAM_WIDTH-1:0] mem [NUM_BUFS][RAM_DEPTH];
  logic [RAM_WIDTH-1:0] s1_data;
  logic [2:1]           vld_pipe;
  logic                 wr_acc, rd_acc, commit_ok, release_ok;

  function automatic logic [BID_W-1:0] ptr_inc(input logic [BID_W-1:0] p);
    return (p == BID_W'(NUM_BUFS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_buf_ready = !full[wr_ptr];
  assign rd_buf_valid = full[rd_ptr];
  assign wr_buf_id    = wr_ptr;
  assign rd_buf_id    = rd_ptr;
  assign wr_acc       = wea & wr_buf_ready;
  assign rd_acc       = enb & rd_buf_valid;
  assign commit_ok    = wr_commit & wr_buf_ready;
  assign release_ok   = rd_release & rd_buf_valid;

  // Byte-lane writes into the writer-owned bank; contents survive reset.
  always_ff @(posedge clka) begin
    if (rstb && wr_acc)
      for (int i = 0; i < BE_W; i++)
        if (bea[i]) mem[wr_ptr][addra][8*i +: 8] <= dina[8*i +: 8];
  end

  // Ownership handshake: commit and release touch different banks, so both
  // may apply in the same cycle. Illegal commands are flagged and dropped.
  always_ff @(posedge clka) begin
    if (!rstb) begin
      full    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cmd_err <= 1'b0;
    end else begin
      if (commit_ok) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (release_ok) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ptr_inc(rd_ptr);
      end
      cmd_err <= (wr_commit & !wr_buf_ready) | (rd_release & !rd_buf_valid);
    end
  end

  // Read stage 1: data holds between reads; valid marks a fresh result.
  always_ff @(posedge clka) begin
    if (!rstb) begin
      s1_data     <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      if (rd_acc) s1_data <= mem[rd_ptr][addrb];
      vld_pipe[1] <= rd_acc | (HOLD1 & vld_pipe[1] & !regceb);
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_oreg
      logic [RAM_WIDTH-1:0] s2_data;
      // Output register: loads from stage 1 only while regceb is high.
      always_ff @(posedge clka) begin
        if (!rstb) begin
          s2_data     <= '0;
          vld_pipe[2] <= 1'b0;
        end else if (regceb) begin
          s2_data     <= s1_data;
          vld_pipe[2] <= vld_pipe[1];
        end
      end
      assign doutb       = s2_data;
      assign doutb_valid = vld_pipe[2];
    end else begin : g_noreg
      assign vld_pipe[2] = vld_pipe[1];
      assign doutb       = s1_data;
      assign doutb_valid = vld_pipe[2];
    end
  endgenerate

endmodule

// File: tb/tb_sim_pingpong_bram.sv
// Bench for sim_pingpong_bram: a 1-cycle and a 2-cycle-latency instance share
// one stimulus stream and are compared every cycle against a bank-count model.
module tb_sim_pingpong_bram;
  localparam int W = 64, D = 16, N = 2;

  logic          clk = 1'b0;
  logic          rstb = 1'b0, wea = 1'b0, wr_commit = 1'b0;
  logic          enb = 1'b0, regceb = 1'b1, rd_release = 1'b0;
  logic [7:0]    bea = '0;
  logic [3:0]    addra = '0, addrb = '0;
  logic [W-1:0]  dina = '0;

  logic          l1_wrdy, l1_rdv, l1_dv, l1_err, l2_wrdy, l2_rdv, l2_dv, l2_err;
  logic [0:0]    l1_wid, l1_rid, l2_wid, l2_rid;
  logic [W-1:0]  l1_dout, l2_dout;

  int tests = 0, fails = 0;

  // Reference model: bank contents plus commit/release counts.
  logic [W-1:0] mm [N][D];
  int           commits = 0, releases = 0;
  logic [W-1:0] m1d = '0, s1d = '0, s2d = '0;
  logic         m1v = 1'b0, s1v = 1'b0, s2v = 1'b0, merr = 1'b0;
  logic [W-1:0] saved;

  always #5 clk = ~clk;

  sim_pingpong_bram #(.RAM_WIDTH(W), .RAM_DEPTH(D), .NUM_BUFS(N), .RD_LATENCY(1)) u_l1 (
    .clka(clk), .rstb(rstb), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
    .wr_commit(wr_commit), .wr_buf_ready(l1_wrdy), .wr_buf_id(l1_wid),
    .enb(enb), .addrb(addrb), .regceb(regceb), .rd_release(rd_release),
    .rd_buf_valid(l1_rdv), .rd_buf_id(l1_rid), .doutb(l1_dout),
    .doutb_valid(l1_dv), .cmd_err(l1_err));

  sim_pingpong_bram #(.RAM_WIDTH(W), .RAM_DEPTH(D), .NUM_BUFS(N), .RD_LATENCY(2)) u_l2 (
    .clka(clk), .rstb(rstb), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
    .wr_commit(wr_commit), .wr_buf_ready(l2_wrdy), .wr_buf_id(l2_wid),
    .enb(enb), .addrb(addrb), .regceb(regceb), .rd_release(rd_release),
    .rd_buf_valid(l2_rdv), .rd_buf_id(l2_rid), .doutb(l2_dout),
    .doutb_valid(l2_dv), .cmd_err(l2_err));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int cnt;
    logic [W-1:0] wid, rid;
    cnt = commits - releases;
    wid = W'(commits % N);
    rid = W'(releases % N);
    chk("l1_wr_ready", W'(l1_wrdy), W'(cnt < N));
    chk("l1_rd_valid", W'(l1_rdv),  W'(cnt > 0));
    chk("l1_wr_id",    W'(l1_wid),  wid);
    chk("l1_rd_id",    W'(l1_rid),  rid);
    chk("l1_doutb",    l1_dout,     m1d);
    chk("l1_dvalid",   W'(l1_dv),   W'(m1v));
    chk("l1_cmd_err",  W'(l1_err),  W'(merr));
    chk("l2_wr_ready", W'(l2_wrdy), W'(cnt < N));
    chk("l2_rd_valid", W'(l2_rdv),  W'(cnt > 0));
    chk("l2_wr_id",    W'(l2_wid),  wid);
    chk("l2_rd_id",    W'(l2_rid),  rid);
    chk("l2_doutb",    l2_dout,     s2d);
    chk("l2_dvalid",   W'(l2_dv),   W'(s2v));
    chk("l2_cmd_err",  W'(l2_err),  W'(merr));
  endtask

  // Advance the model with the current inputs, clock once, then compare.
  task automatic step();
    int cnt, wp, rp;
    bit wr_ok, rd_ok, acc;
    logic [W-1:0] rdat;
    cnt = commits - releases;
    wp = commits % N;
    rp = releases % N;
    wr_ok = (cnt < N);
    rd_ok = (cnt > 0);
    if (!rstb) begin
      commits = 0; releases = 0;
      m1d = '0; m1v = 0; s1d = '0; s1v = 0; s2d = '0; s2v = 0; merr = 0;
    end else begin
      acc  = enb && rd_ok;
      rdat = mm[rp][addrb];
      if (acc) m1d = rdat;
      m1v = acc;
      if (regceb) begin s2d = s1d; s2v = s1v; end
      if (acc) begin s1d = rdat; s1v = 1; end
      else if (regceb) s1v = 0;
      if (wea && wr_ok)
        for (int b = 0; b < 8; b++)
          if (bea[b]) mm[wp][addra][8*b +: 8] = dina[8*b +: 8];
      merr = (wr_commit && !wr_ok) || (rd_release && !rd_ok);
      if (wr_commit && wr_ok) commits++;
      if (rd_release && rd_ok) releases++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    wea = 0; wr_commit = 0; enb = 0; rd_release = 0;
  endtask

  initial begin
    for (int b = 0; b < N; b++)
      for (int a = 0; a < D; a++) mm[b][a] = 'x;

    // Reset state
    rstb = 0; step(); step(); rstb = 1;
    chk("rst_wr_ready", W'(l1_wrdy), 1);
    chk("rst_doutb", l1_dout, 0);

    // Fill bank0, commit together with the last write
    for (int i = 0; i < 4; i++) begin
      wea = 1; bea = 8'hFF; addra = 4'(i); dina = W'((i + 1) * 'h11);
      wr_commit = (i == 3);
      step();
    end
    idle();
    chk("commit_rd_valid", W'(l1_rdv), 1);
    enb = 1; addrb = 2; step(); idle();
    chk("rd_addr2", l1_dout, 64'h33);
    chk("rd_addr2_vld", W'(l1_dv), 1);
    step();

    // Byte lanes in bank1, then both banks full
    wea = 1; bea = 8'hFF; addra = 5; dina = '1; step();
    bea = 8'h0F; dina = '0; wr_commit = 1; step(); idle();
    chk("full_wr_ready", W'(l1_wrdy), 0);

    // Write and commit while full are dropped; commit flags an error
    wea = 1; bea = 8'hFF; addra = 0; dina = 64'hDEAD_BEEF; wr_commit = 1; step(); idle();
    chk("bp_cmd_err", W'(l1_err), 1);
    chk("bp_wr_id", W'(l1_wid), 0);
    step();
    chk("bp_err_pulse", W'(l1_err), 0);
    enb = 1; addrb = 0; step(); idle();
    chk("bp_ignored_wr", l1_dout, 64'h11);

    // Release bank0 while reading from it
    rd_release = 1; enb = 1; addrb = 1; step(); idle();
    chk("rel_rd_data", l1_dout, 64'h22);
    chk("rel_rd_id", W'(l1_rid), 1);
    enb = 1; addrb = 5; step(); idle();
    chk("byte_lanes", l1_dout, 64'hFFFF_FFFF_0000_0000);

    // Same-cycle release of bank1 and commit of bank0
    saved = {$urandom, $urandom};
    wea = 1; bea = 8'hFF; addra = 7; dina = saved; step(); idle();
    rd_release = 1; enb = 1; addrb = 5; wr_commit = 1; step(); idle();
    chk("same_rd_data", l1_dout, 64'hFFFF_FFFF_0000_0000);
    chk("same_rd_id", W'(l1_rid), 0);
    chk("same_wr_id", W'(l1_wid), 1);
    chk("same_wr_ready", W'(l1_wrdy), 1);

    // Output register held off by regceb
    step(); step();
    regceb = 0; enb = 1; addrb = 7; step(); idle();
    chk("oreg_hold0", W'(l2_dv), 0);
    step(); chk("oreg_hold1", W'(l2_dv), 0);
    step(); chk("oreg_hold2", W'(l2_dv), 0);
    regceb = 1; step();
    chk("oreg_vld", W'(l2_dv), 1);
    chk("oreg_data", l2_dout, saved);
    step();

    // Reset with a read in flight
    enb = 1; addrb = 0; rstb = 0; step(); idle();
    chk("rst_inflight_l1", W'(l1_dv), 0);
    chk("rst_inflight_l2", W'(l2_dv), 0);
    chk("rst_rd_valid", W'(l1_rdv), 0);
    step(); rstb = 1;
    rd_release = 1; step(); idle();
    chk("empty_rel_err", W'(l1_err), 1);
    wr_commit = 1; step(); idle();
    enb = 1; addrb = 7; step(); idle();
    chk("mem_kept", l1_dout, saved);
    step();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      rstb       = ($urandom_range(0, 99) != 0);
      wea        = $urandom_range(0, 1) == 1;
      bea        = 8'($urandom);
      addra      = 4'($urandom_range(0, D - 1));
      dina       = {$urandom, $urandom};
      wr_commit  = ($urandom_range(0, 5) == 0);
      enb        = $urandom_range(0, 1) == 1;
      addrb      = 4'($urandom_range(0, D - 1));
      regceb     = ($urandom_range(0, 2) != 0);
      rd_release = ($urandom_range(0, 5) == 0);
      step();
    end
    rstb = 1; idle(); regceb = 1; step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
